// File: rtl/buffer_0_read_arbiter.sv
// buffer_0_read_arbiter
//   Shares the single agg read port of buffer_0 between NUM_REQ aggregation lanes.
//   The arbiter is round-robin and grants one read per cycle. A tag pipeline carries each
//   read's lane id alongside the buffer read latency, so every returned word goes back to
//   the lane that issued it. The sticky err_orphan flag is set when a tag and the returned
//   data do not line up.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_addr   per-lane read requests (lane i addr at [i*ADDR_W +: ADDR_W])
//   req_ready            one-hot grant (combinational), transfer = valid & ready
//   arb_hold             suppresses new grants for the current cycle
//   buf_read_addr_valid  registered read issue towards buffer_0
//   buf_read_addr        registered read address towards buffer_0
//   buf_read_data_valid  read return from buffer_0 (READ_LATENCY after issue)
//   buf_read_data        read data from buffer_0
//   rsp_valid            one-hot lane owning rsp_data (registered)
//   rsp_data             returned word (registered)
//   outstanding          reads issued but not yet answered
//   err_orphan           sticky tag/data misalignment flag
module buffer_0_read_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned BUFFER_ADDR_WIDTH = 11,
  parameter int unsigned BUFFER_DATA_WIDTH = 512,
  parameter int unsigned READ_LATENCY      = 4,
  parameter int unsigned ID_WIDTH          = $clog2(NUM_REQ),
  localparam int unsigned CNT_WIDTH        = $clog2(READ_LATENCY + 2)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*BUFFER_ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic                                   arb_hold,
  output logic                                   buf_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0]           buf_read_addr,
  input  logic                                   buf_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0]           buf_read_data,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [BUFFER_DATA_WIDTH-1:0]           rsp_data,
  output logic [CNT_WIDTH-1:0]                   outstanding,
  output logic                                   err_orphan
);

  localparam logic [ID_WIDTH-1:0]  LastId = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(READ_LATENCY + 1);

  logic [ID_WIDTH-1:0]          ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]          win_id, scan_id;
  logic                         win_found, transfer;
  logic [BUFFER_ADDR_WIDTH-1:0] sel_addr;

  logic                         addr_valid_q;
  logic [BUFFER_ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]          issue_id_q;

  logic [READ_LATENCY-1:0]      tag_v_q;
  logic [ID_WIDTH-1:0]          tag_id_q [READ_LATENCY];

  logic                         tag_last_v, hit, mismatch;
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic [BUFFER_DATA_WIDTH-1:0] rsp_data_q;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         err_q;

  // Round-robin search starting at ptr_q, wrapping at NUM_REQ.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    scan_id   = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
      scan_id = (scan_id == LastId) ? '0 : scan_id + ID_WIDTH'(1);
    end
  end

  assign transfer  = win_found & ~arb_hold & ~rst;
  assign req_ready = transfer ? (NUM_REQ'(1) << win_id) : '0;
  assign sel_addr  = req_addr[win_id*BUFFER_ADDR_WIDTH +: BUFFER_ADDR_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (win_id == LastId) ? '0 : win_id + ID_WIDTH'(1);
    end
  end

  // The final tag stage lines up with buf_read_data_valid of the matching read.
  assign tag_last_v = tag_v_q[READ_LATENCY-1];
  assign hit        = tag_last_v & buf_read_data_valid;
  assign mismatch   = tag_last_v ^ buf_read_data_valid;

  // Issue and response can coincide; the count is then unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({transfer, hit})
      2'b10:   if (cnt_q != CntMax) cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   if (cnt_q != '0)     cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      issue_id_q   <= '0;
      tag_v_q      <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        tag_id_q[i] <= '0;
      end
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      addr_valid_q <= transfer;
      addr_q       <= transfer ? sel_addr : '0;
      issue_id_q   <= transfer ? win_id : '0;
      // Stage 0 captures the issue register, so the tag trails the buffer by exactly
      // READ_LATENCY cycles.
      tag_v_q[0]   <= addr_valid_q;
      tag_id_q[0]  <= issue_id_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      rsp_valid_q  <= hit ? (NUM_REQ'(1) << tag_id_q[READ_LATENCY-1]) : '0;
      rsp_data_q   <= hit ? buf_read_data : '0;
      cnt_q        <= cnt_d;
      err_q        <= err_q | mismatch;
    end
  end

  assign buf_read_addr_valid = addr_valid_q;
  assign buf_read_addr       = addr_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_data            = rsp_data_q;
  assign outstanding         = cnt_q;
  assign err_orphan          = err_q;

endmodule
